// File: rtl/update_global_lvl_state.sv
// update_global_lvl_state: pushes or backtracks the global decision level and mirrors it into the lvl-state BRAM
module update_global_lvl_state #(
    parameter int WIDTH_LVL              = 16,
    parameter int WIDTH_BIN_ID           = 10,
    parameter int WIDTH_LVL_STATES       = 11,
    parameter int ADDR_WIDTH_LVLS_STATES = 9
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start_push,
    input  logic [WIDTH_BIN_ID-1:0]           push_bin_i,
    input  logic                              start_clear,
    input  logic [WIDTH_LVL-1:0]              clear_lvl_i,
    output logic                              apply_update_o,
    output logic                              done_update,
    output logic [WIDTH_LVL-1:0]              cur_lvl_o,
    output logic                              overflow_o,
    output logic                              ram_we_l_state_o,
    output logic [WIDTH_LVL_STATES-1:0]       ram_data_l_state_o,
    output logic [ADDR_WIDTH_LVLS_STATES-1:0] ram_addr_l_state_o
);
    typedef enum logic [1:0] {IDLE, PUSH, CLEAR, DONE} state_t;
    localparam logic [WIDTH_LVL-1:0] MAX_LVL = WIDTH_LVL'((1 << ADDR_WIDTH_LVLS_STATES) - 1);
    localparam logic [WIDTH_LVL-1:0] ONE = WIDTH_LVL'(1);
    state_t                            state_q, state_d;
    logic [WIDTH_LVL-1:0]              cur_lvl_q, cur_lvl_d, tgt_q, tgt_d;
    logic [WIDTH_BIN_ID-1:0]           bin_q, bin_d;
    logic                              ovf_q, ovf_d, we_q, we_d, done_q, done_d, full;
    logic [ADDR_WIDTH_LVLS_STATES-1:0] addr_q, addr_d;
    logic [WIDTH_LVL_STATES-1:0]       data_q, data_d;
    assign full               = cur_lvl_q >= MAX_LVL;
    assign apply_update_o     = we_q;
    assign ram_we_l_state_o   = we_q;
    assign ram_addr_l_state_o = addr_q;
    assign ram_data_l_state_o = data_q;
    assign done_update        = done_q;
    assign cur_lvl_o          = cur_lvl_q;
    assign overflow_o         = ovf_q;
    // next state, level bookkeeping and the write-port command registered for the following cycle
    always_comb begin
        state_d   = state_q;
        cur_lvl_d = cur_lvl_q;
        tgt_d     = tgt_q;
        bin_d     = bin_q;
        ovf_d     = ovf_q;
        we_d      = 1'b0;
        addr_d    = '0;
        data_d    = '0;
        done_d    = state_q == DONE;
        case (state_q)
            IDLE: begin
                if (start_clear) begin
                    tgt_d   = clear_lvl_i;
                    state_d = clear_lvl_i < cur_lvl_q ? CLEAR : DONE;
                end else if (start_push) begin
                    bin_d   = push_bin_i;
                    state_d = PUSH;
                end
            end
            PUSH: begin
                we_d      = !full;
                addr_d    = full ? '0 : ADDR_WIDTH_LVLS_STATES'(cur_lvl_q + ONE);
                data_d    = full ? '0 : WIDTH_LVL_STATES'({bin_q, 1'b0});
                cur_lvl_d = full ? cur_lvl_q : cur_lvl_q + ONE;
                ovf_d     = ovf_q | full;
                state_d   = DONE;
            end
            CLEAR: begin
                we_d      = 1'b1;
                addr_d    = ADDR_WIDTH_LVLS_STATES'(cur_lvl_q);
                cur_lvl_d = cur_lvl_q - ONE;
                state_d   = cur_lvl_d == tgt_q ? DONE : CLEAR;
            end
            default: state_d = IDLE;
        endcase
    end
    // state and output registers; reset abandons any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cur_lvl_q <= '0;
            tgt_q     <= '0;
            bin_q     <= '0;
            ovf_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_lvl_q <= cur_lvl_d;
            tgt_q     <= tgt_d;
            bin_q     <= bin_d;
            ovf_q     <= ovf_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            done_q    <= done_d;
        end
    end
endmodule

// File: tb/tb_update_global_lvl_state.sv
// tb_update_global_lvl_state: trace-model and directed-literal checks of the level-state updater
module tb_update_global_lvl_state;
    typedef struct packed {
        logic        we;
        logic [8:0]  a;
        logic [10:0] d;
        logic        dn;
        logic [15:0] l;
        logic        o;
    } exp_t;
    logic        clk = 0, rst = 1;
    logic        start_push = 0, start_clear = 0;
    logic [9:0]  push_bin_i = 0;
    logic [15:0] clear_lvl_i = 0;
    logic        apply, done, ovf, we;
    logic [15:0] lvl;
    logic [10:0] data;
    logic [8:0]  addr;
    logic        sp2 = 0, sc2 = 0;
    logic [9:0]  pb2 = 0;
    logic [15:0] cl2 = 0;
    logic        apply2, done2, ovf2, we2;
    logic [15:0] lvl2;
    logic [10:0] data2;
    logic [1:0]  addr2;
    int          checks = 0, errors = 0, m_lvl = 0, w2 = 0, d2 = 0;
    bit          chk_en = 0, m_ovf = 0;
    exp_t        q[$];
    exp_t        last = '0;
    int          wa[$], wd[$], a2[$], dd2[$];

    update_global_lvl_state dut (
        .clk(clk), .rst(rst), .start_push(start_push), .push_bin_i(push_bin_i),
        .start_clear(start_clear), .clear_lvl_i(clear_lvl_i), .apply_update_o(apply),
        .done_update(done), .cur_lvl_o(lvl), .overflow_o(ovf), .ram_we_l_state_o(we),
        .ram_data_l_state_o(data), .ram_addr_l_state_o(addr)
    );

    update_global_lvl_state #(.ADDR_WIDTH_LVLS_STATES(2)) dut2 (
        .clk(clk), .rst(rst), .start_push(sp2), .push_bin_i(pb2),
        .start_clear(sc2), .clear_lvl_i(cl2), .apply_update_o(apply2),
        .done_update(done2), .cur_lvl_o(lvl2), .overflow_o(ovf2), .ram_we_l_state_o(we2),
        .ram_data_l_state_o(data2), .ram_addr_l_state_o(addr2)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(bit w, int a, int d, bit dn, int l, bit o);
        exp_t e;
        e.we = w; e.a = 9'(a); e.d = 11'(d); e.dn = dn; e.l = 16'(l); e.o = o;
        return e;
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // per-cycle comparison of the main DUT against the expected trace (idle when the trace is empty)
    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            e = q.size() != 0 ? q.pop_front() : mk(0, 0, 0, 0, int'(last.l), last.o);
            last = e;
            checks++;
            if ({we, apply, addr, data, done, lvl, ovf} !== {e.we, e.we, e.a, e.d, e.dn, e.l, e.o}) begin
                errors++;
                $display("FAIL cycle t=%0t got we=%0b apply=%0b addr=%0d data=0x%0h done=%0b lvl=%0d ovf=%0b want we=%0b addr=%0d data=0x%0h done=%0b lvl=%0d ovf=%0b",
                         $time, we, apply, addr, data, done, lvl, ovf, e.we, e.a, e.d, e.dn, e.l, e.o);
            end
            if (we === 1'b1) begin
                wa.push_back(int'(addr));
                wd.push_back(int'(data));
            end
            if (we2 === 1'b1) begin
                w2++;
                a2.push_back(int'(addr2));
                dd2.push_back(int'(data2));
            end
            if (done2 === 1'b1) d2++;
            checks++;
            if (apply2 !== we2) begin
                errors++;
                $display("FAIL apply2 got %0b want %0b", apply2, we2);
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 64 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
            q.delete();
        end
    endtask

    // one request: drive it, build the expected trace from level arithmetic, scramble inputs afterwards
    task automatic req(input bit p, input bit c, input int b, input int t, input int hold);
        @(negedge clk);
        #1;
        start_push = p; start_clear = c; push_bin_i = 10'(b); clear_lvl_i = 16'(t);
        q.push_back(mk(0, 0, 0, 0, m_lvl, m_ovf));
        if (c) begin
            while (m_lvl > t) begin
                q.push_back(mk(1, m_lvl, 0, 0, m_lvl - 1, m_ovf));
                m_lvl--;
            end
        end else if (m_lvl < 511) begin
            m_lvl++;
            q.push_back(mk(1, m_lvl, b * 2, 0, m_lvl, m_ovf));
        end else begin
            m_ovf = 1;
            q.push_back(mk(0, 0, 0, 0, m_lvl, 1));
        end
        q.push_back(mk(0, 0, 0, 1, m_lvl, m_ovf));
        @(negedge clk);
        #1;
        start_clear = 0; push_bin_i = ~push_bin_i; clear_lvl_i = ~clear_lvl_i;
        repeat (hold) @(negedge clk);
        #1 start_push = 0;
        drain();
    endtask

    task automatic push2(input int b);
        @(negedge clk);
        #1 sp2 = 1; pb2 = 10'(b);
        @(negedge clk);
        #1 sp2 = 0; pb2 = 0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk_en = 1;
        chk("reset_lvl", int'(lvl), 0);
        chk("reset_we", int'(we), 0);
        chk("reset_ovf", int'(ovf), 0);
        req(1, 0, 5, 0, 0);
        req(1, 0, 7, 0, 0);
        req(1, 0, 9, 0, 0);
        chk("push_lvl", int'(lvl), 3);
        chk("push_nw", wa.size(), 3);
        chk("push_a1", wa[0], 1); chk("push_d1", wd[0], 'h00A);
        chk("push_a2", wa[1], 2); chk("push_d2", wd[1], 'h00E);
        chk("push_a3", wa[2], 3); chk("push_d3", wd[2], 'h012);
        wa.delete(); wd.delete();
        req(0, 1, 0, 1, 0);
        chk("clr_lvl", int'(lvl), 1);
        chk("clr_nw", wa.size(), 2);
        chk("clr_a1", wa[0], 3); chk("clr_a2", wa[1], 2); chk("clr_d", wd[0] | wd[1], 0);
        req(1, 0, 'h3FF, 0, 0);
        wa.delete(); wd.delete();
        req(0, 1, 0, 2, 0);
        req(0, 1, 0, 5, 0);
        chk("noclr_nw", wa.size(), 0);
        chk("noclr_lvl", int'(lvl), 2);
        req(1, 0, 1, 0, 0);
        wa.delete(); wd.delete();
        req(1, 1, 'h155, 0, 2);
        chk("both_lvl", int'(lvl), 0);
        chk("both_nw", wa.size(), 3);
        chk("both_a3", wa[2], 1);
        chk("both_d", wd[0] | wd[1] | wd[2], 0);
        for (int i = 0; i < 4; i++) req(1, 0, i + 2, 0, 0);
        chk("pre_rst_lvl", int'(lvl), 4);
        wa.delete(); wd.delete();
        @(negedge clk);
        #1 start_clear = 1; clear_lvl_i = 0;
        q.push_back(mk(0, 0, 0, 0, 4, 0));
        q.push_back(mk(1, 4, 0, 0, 3, 0));
        q.push_back(mk(1, 3, 0, 0, 2, 0));
        repeat (5) q.push_back(mk(0, 0, 0, 0, 0, 0));
        m_lvl = 0;
        @(negedge clk);
        #1 start_clear = 0;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1;
        @(negedge clk);
        #1 rst = 0;
        drain();
        chk("rst_mid_nw", wa.size(), 2);
        chk("rst_mid_a", wa[0], 4);
        chk("rst_mid_lvl", int'(lvl), 0);
        push2(5); push2(6); push2(7);
        chk("ov_pre", int'(ovf2), 0);
        chk("ov_pre_lvl", int'(lvl2), 3);
        push2(8);
        chk("ov_nw", w2, 3);
        chk("ov_a1", a2[0], 1); chk("ov_a3", a2[2], 3);
        chk("ov_d1", dd2[0], 'h00A);
        chk("ov_flag", int'(ovf2), 1);
        chk("ov_lvl", int'(lvl2), 3);
        chk("ov_done", d2, 4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/update_global_lvl_state.md
UPDATE_GLOBAL_LVL_STATE -- requirements
Module: update_global_lvl_state

Interface
REQ-001 SHALL have parameter WIDTH_LVL, default 16, global decision level width.
REQ-002 SHALL have parameter WIDTH_BIN_ID, default 10, bin identifier width.
REQ-003 SHALL have parameter WIDTH_LVL_STATES, default 11, lvl-state word width, minimum WIDTH_BIN_ID+1.
REQ-004 SHALL have parameter ADDR_WIDTH_LVLS_STATES, default 9, lvl-state BRAM address width.
REQ-005 SHALL provide clk  in  1  sole clock, all logic on rising edge.
REQ-006 SHALL provide rst  in  1  synchronous, active-high reset.
REQ-007 SHALL provide start_push  in  1  request: open a new level for push_bin_i.
REQ-008 SHALL provide push_bin_i  in  WIDTH_BIN_ID  bin that made the new decision.
REQ-009 SHALL provide start_clear  in  1  request: backtrack to clear_lvl_i.
REQ-010 SHALL provide clear_lvl_i  in  WIDTH_LVL  target level after backtrack.
REQ-011 SHALL provide apply_update_o  out  1  BRAM port ownership, for the BRAM mux.
REQ-012 SHALL provide done_update  out  1  one-cycle completion pulse.
REQ-013 SHALL provide cur_lvl_o  out  WIDTH_LVL  current global level, 0 = no decisions.
REQ-014 SHALL provide overflow_o  out  1  sticky push-overflow flag.
REQ-015 SHALL provide ram_we_l_state_o  out  1, ram_data_l_state_o  out  WIDTH_LVL_STATES, ram_addr_l_state_o  out  ADDR_WIDTH_LVLS_STATES  lvl-state BRAM write port.

Function
REQ-016 SHALL encode the lvl-state word as {zero pad, dcd_bin[WIDTH_BIN_ID], has_bkt[1]}, has_bkt in bit 0; address N holds level N; address 0 unused.
REQ-017 SHALL implement FSM IDLE, PUSH, CLEAR, DONE; IDLE->CLEAR on start_clear with clear_lvl_i<cur_lvl; IDLE->DONE on start_clear with clear_lvl_i>=cur_lvl; IDLE->PUSH on start_push; PUSH->DONE; CLEAR->DONE after last entry; DONE->IDLE.
REQ-018 SHALL give start_clear priority when both starts are asserted in the same IDLE cycle; starts outside IDLE SHALL be ignored.
REQ-019 SHALL latch push_bin_i and clear_lvl_i in the start cycle; later changes are ignored.
REQ-020 PUSH SHALL register one write: addr cur_lvl+1 (truncated to ADDR width), data {push_bin_i, 1'b0}; cur_lvl increments by 1, visible in the write cycle.
REQ-021 Push with cur_lvl = 2^ADDR_WIDTH_LVLS_STATES-1 SHALL issue no write, leave cur_lvl unchanged, set overflow_o, and complete with done_update as normal.
REQ-022 CLEAR SHALL write all-zero data to addresses cur_lvl, cur_lvl-1, ..., clear_lvl_i+1, one per cycle, descending; N = cur_lvl-clear_lvl_i writes; cur_lvl_o = clear_lvl_i by the done_update cycle.
REQ-023 Clear with clear_lvl_i>=cur_lvl SHALL issue no writes and leave cur_lvl unchanged.
REQ-024 Write-port outputs SHALL be registered; with the start sampled on edge 0: we high cycles 2..N+1 (push N=1), done_update high cycle N+2; no-write cases: done_update in cycle 2.
REQ-025 apply_update_o SHALL be high exactly in cycles where ram_we_l_state_o is high; otherwise addr/data SHALL be 0.
REQ-026 done_update SHALL be high for exactly one cycle per accepted request.

Reset
REQ-027 With rst high at an edge: FSM=IDLE, cur_lvl_o=0, overflow_o=0, done_update=0, apply_update_o=0, ram_we_l_state_o=0, ram_addr_l_state_o=0, ram_data_l_state_o=0 from the next cycle.
REQ-028 Reset mid-PUSH or mid-CLEAR SHALL abandon the operation: no further writes, no done_update.
REQ-029 overflow_o SHALL clear only on reset.

Verification
REQ-030 From reset, push bins 5,7,9 -> writes (1,0x00A),(2,0x00E),(3,0x012); cur_lvl_o=3; three done pulses.
REQ-031 cur_lvl=3, clear to 1 -> we high 2 cycles, addrs 3 then 2, data 0; cur_lvl_o=1; done in cycle 4.
REQ-032 cur_lvl=2, clear to 2 (and to 5) -> no writes, done in cycle 2, cur_lvl_o=2.
REQ-033 Both starts in one cycle, cur_lvl=3, clear_lvl_i=0 -> three zero writes to 3,2,1; no push write; cur_lvl_o=0.
REQ-034 ADDR_WIDTH_LVLS_STATES=2, push 4 times -> writes at 1,2,3; 4th push no write, overflow_o=1, cur_lvl_o=3, done pulses.
REQ-035 cur_lvl=4, clear to 0, rst in cycle 3 -> writes only addrs 4 (cycle 2) and at most 3, then we low, cur_lvl_o=0, no done_update.
